// File: rtl/fisqrt_rr_arbiter.sv
// Round-robin front end that shares one fastInvSqrt Q12.4 core among N_REQ requesters.
// Optional watchdog: define FISQRT_ARB_TIMEOUT_EN to abort stuck operations after TIMEOUT_CYC cycles.
module fisqrt_rr_arbiter #(
   parameter int N_REQ       = 4,
   parameter int DATA_W      = 16,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        rsp_valid,
   input  logic [N_REQ-1:0]        rsp_ready,
   output logic [DATA_W-1:0]       rsp_data,
   output logic                    rsp_err,
   output logic                    core_rst,
   output logic [DATA_W-1:0]       core_data_in,
   output logic                    core_valid_in,
   input  logic                    core_ready_in,
   input  logic [DATA_W-1:0]       core_data_out,
   input  logic                    core_valid_out,
   output logic                    core_ready_out
);

   localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   if (N_REQ < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
      $error("fisqrt_rr_arbiter: N_REQ and TIMEOUT_CYC must be at least 1");
   end

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          state;
   logic [GW-1:0]   ptr;
   logic [GW-1:0]   grant;
   logic [GW-1:0]   winner;
   logic [GW-1:0]   next_ptr;
   logic            any_req;
   logic            grant_fire;

   // Winner is the first valid requester at or after ptr, wrapping around.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      any_req = 1'b0;
      winner  = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         int idx;
         idx = (int'(ptr) + k) % N_REQ;
         if (req_valid[idx]) begin
            any_req = 1'b1;
            winner  = GW'(idx);
         end
      end
   end

   assign next_ptr   = (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
   // No grant while the core is still held in reset.
   assign grant_fire = (state == IDLE) && !core_rst && any_req;

   always_comb begin
      req_ready = '0;
      if (grant_fire) req_ready[winner] = 1'b1;
   end

`ifdef FISQRT_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TO_W-1:0] to_cnt;
   logic            to_hit;
   logic            rst_hold;

   assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
   assign rsp_err = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         ptr            <= '0;
         grant          <= '0;
         core_rst       <= 1'b1;
         core_data_in   <= '0;
         core_valid_in  <= 1'b0;
         core_ready_out <= 1'b0;
         rsp_valid      <= '0;
         rsp_data       <= '0;
`ifdef FISQRT_ARB_TIMEOUT_EN
         rsp_err        <= 1'b0;
         to_cnt         <= '0;
         rst_hold       <= 1'b0;
`endif
      end else begin
`ifdef FISQRT_ARB_TIMEOUT_EN
         core_rst <= rst_hold;
         rst_hold <= 1'b0;
`else
         core_rst <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (grant_fire) begin
                  core_data_in  <= req_data[winner*DATA_W +: DATA_W];
                  grant         <= winner;
                  ptr           <= next_ptr;
                  core_valid_in <= 1'b1;
                  state         <= ISSUE;
`ifdef FISQRT_ARB_TIMEOUT_EN
                  to_cnt        <= '0;
                  rsp_err       <= 1'b0;
`endif
               end
            end
            ISSUE: begin
               if (core_ready_in) begin
                  core_valid_in  <= 1'b0;
                  core_ready_out <= 1'b1;
                  state          <= WAIT;
               end
            end
            WAIT: begin
               if (core_valid_out && core_ready_out) begin
                  rsp_data         <= core_data_out;
                  core_ready_out   <= 1'b0;
                  rsp_valid[grant] <= 1'b1;
                  state            <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready[grant]) begin
                  rsp_valid <= '0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
`ifdef FISQRT_ARB_TIMEOUT_EN
         // Watchdog overrides any progress made in the same cycle it expires.
         if (state == ISSUE || state == WAIT) begin
            if (to_hit) begin
               state            <= RESP;
               rsp_data         <= '1;
               rsp_err          <= 1'b1;
               rsp_valid[grant] <= 1'b1;
               core_valid_in    <= 1'b0;
               core_ready_out   <= 1'b0;
               core_rst         <= 1'b1;
               rst_hold         <= 1'b1;
            end else begin
               to_cnt <= to_cnt + 1'b1;
            end
         end
`endif
      end
   end

endmodule
